// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for and filters lock,
// staggers per-channel clock enables, releases the system reset and
// re-runs the sequence on lock loss or a relock request.
// Optional feature macro: PLLSEQ_RETRY_LIMIT_EN (retry limit -> sticky FAULT state).
module pll_lock_sequencer #(
    parameter int unsigned NUM_CLK        = 3,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_FILT      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned STAGGER        = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned MAX_RETRY      = 7
) (
    input  logic               clkin,
    input  logic               resetn,
    input  logic               pll_lock,
    input  logic [NUM_CLK-1:0] ch_mask,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [3:0]         retry_cnt,
    output logic [3:0]         lost_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_CLK + 1);
    localparam int unsigned SAT_W = 4;

    // Reject parameter sets the counters and enable index cannot represent
    if (NUM_CLK < 1 || NUM_CLK > 7 || MAX_RETRY > 15) begin : g_param_check
        $error("pll_lock_sequencer: unsupported NUM_CLK or MAX_RETRY");
    end

    typedef enum logic [2:0] {
        ST_PLLRST,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_ENABLE,
        ST_RUN
`ifdef PLLSEQ_RETRY_LIMIT_EN
        , ST_FAULT
`endif
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   timer_q, timer_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [NUM_CLK-1:0] mask_q, mask_n;
    logic [1:0]         sync_q;
    logic               lock_s;

    logic               pll_reset_n;
    logic [NUM_CLK-1:0] enclk_n;
    logic               sys_rst_n_n;
    logic               ready_n;
    logic [SAT_W-1:0]   retry_n, lost_n;
    logic [SAT_W-1:0]   retry_inc, lost_inc;

    assign lock_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

`ifdef PLLSEQ_RETRY_LIMIT_EN
    logic fault_q, fault_n;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // State register and registered outputs
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_PLLRST;
            timer_q   <= '0;
            idx_q     <= '0;
            mask_q    <= '0;
            pll_reset <= 1'b1;
            enclk     <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            retry_cnt <= '0;
            lost_cnt  <= '0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            idx_q     <= idx_n;
            mask_q    <= mask_n;
            pll_reset <= pll_reset_n;
            enclk     <= enclk_n;
            sys_rst_n <= sys_rst_n_n;
            ready     <= ready_n;
            retry_cnt <= retry_n;
            lost_cnt  <= lost_n;
`ifdef PLLSEQ_RETRY_LIMIT_EN
            fault_q   <= fault_n;
`endif
        end
    end

    // Next-state and next-output decisions
    always_comb begin
        state_n     = state_q;
        timer_n     = timer_q;
        idx_n       = idx_q;
        mask_n      = mask_q;
        pll_reset_n = pll_reset;
        enclk_n     = enclk;
        sys_rst_n_n = sys_rst_n;
        ready_n     = ready;
        retry_n     = retry_cnt;
        lost_n      = lost_cnt;
`ifdef PLLSEQ_RETRY_LIMIT_EN
        fault_n     = fault_q;
`endif
        retry_inc   = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
        lost_inc    = (lost_cnt == 4'hF) ? lost_cnt : lost_cnt + 4'd1;

        if (relock_req) begin
            // Software relock wins over everything, including a lock loss
            state_n     = ST_PLLRST;
            timer_n     = '0;
            pll_reset_n = 1'b1;
            enclk_n     = '0;
            sys_rst_n_n = 1'b0;
            ready_n     = 1'b0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
            if (state_q == ST_FAULT) begin
                fault_n = 1'b0;
                retry_n = '0;
            end
`endif
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (timer_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_n     = ST_WAIT_LOCK;
                        timer_n     = '0;
                        pll_reset_n = 1'b0;
                    end else begin
                        timer_n = timer_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = ST_FILTER;
                        timer_n = '0;
                    end else if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        retry_n     = retry_inc;
                        state_n     = ST_PLLRST;
                        timer_n     = '0;
                        pll_reset_n = 1'b1;
`ifdef PLLSEQ_RETRY_LIMIT_EN
                        if (32'(retry_inc) == MAX_RETRY) begin
                            state_n = ST_FAULT;
                            fault_n = 1'b1;
                        end
`endif
                    end else begin
                        timer_n = timer_q + CNT_W'(1);
                    end
                end
                ST_FILTER: begin
                    if (!lock_s) begin
                        state_n = ST_WAIT_LOCK;
                        timer_n = '0;
                    end else if (timer_q == CNT_W'(LOCK_FILT - 1)) begin
                        // Channel 0 takes its slot on entry to ENABLE
                        state_n    = ST_ENABLE;
                        timer_n    = '0;
                        mask_n     = ch_mask;
                        enclk_n[0] = ch_mask[0];
                        idx_n      = IDX_W'(1);
                    end else begin
                        timer_n = timer_q + CNT_W'(1);
                    end
                end
                ST_ENABLE, ST_RUN: begin
                    if (!lock_s) begin
                        lost_n      = lost_inc;
                        state_n     = ST_PLLRST;
                        timer_n     = '0;
                        pll_reset_n = 1'b1;
                        enclk_n     = '0;
                        sys_rst_n_n = 1'b0;
                        ready_n     = 1'b0;
                    end else if (state_q == ST_ENABLE) begin
                        if (timer_q == CNT_W'(STAGGER - 1)) begin
                            timer_n = '0;
                            if (idx_q == IDX_W'(NUM_CLK)) begin
                                state_n     = ST_RUN;
                                sys_rst_n_n = 1'b1;
                                ready_n     = 1'b1;
                            end else begin
                                for (int unsigned i = 0; i < NUM_CLK; i++) begin
                                    if (IDX_W'(i) == idx_q) begin
                                        enclk_n[i] = mask_q[i];
                                    end
                                end
                                idx_n = idx_q + IDX_W'(1);
                            end
                        end else begin
                            timer_n = timer_q + CNT_W'(1);
                        end
                    end
                end
`ifdef PLLSEQ_RETRY_LIMIT_EN
                ST_FAULT: begin
                    pll_reset_n = 1'b1;
                    enclk_n     = '0;
                    sys_rst_n_n = 1'b0;
                    ready_n     = 1'b0;
                end
`endif
                default: begin
                    state_n     = ST_PLLRST;
                    timer_n     = '0;
                    pll_reset_n = 1'b1;
                    enclk_n     = '0;
                    sys_rst_n_n = 1'b0;
                    ready_n     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up, glitch,
// lock-loss, relock and timeout scenarios, then randomized lock/relock/reset
// traffic compared every cycle against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

    localparam int NUM_CLK   = 3;
    localparam int RST_CYC   = 16;
    localparam int LOCK_FILT = 64;
    localparam int TIMEOUT   = 100;
    localparam int STAGGER   = 8;
    localparam int MAX_RETRY = 3;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_FILT  = 2;
    localparam int PH_EN    = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_FAULT = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pll_lock;
    logic [NUM_CLK-1:0] ch_mask;
    logic               relock_req;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;
    logic               sys_rst_n;
    logic               ready;
    logic               fault;
    logic [3:0]         retry_cnt;
    logic [3:0]         lost_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    pll_lock_sequencer #(
        .NUM_CLK(NUM_CLK), .RST_CYCLES(RST_CYC), .LOCK_FILT(LOCK_FILT),
        .TIMEOUT_CYCLES(TIMEOUT), .STAGGER(STAGGER), .CNT_W(16), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clk), .resetn(rst_n), .pll_lock(pll_lock), .ch_mask(ch_mask),
        .relock_req(relock_req), .pll_reset(pll_reset), .enclk(enclk),
        .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase plus cycles elapsed in that phase
    int         m_ph, m_el, m_retry, m_lost;
    bit         m_fault, m_s1, m_s2;
    logic [2:0] m_mask;

    always @(posedge clk or negedge rst_n) begin : model
        bit ls;
        if (!rst_n) begin
            m_ph = PH_RST; m_el = 0; m_retry = 0; m_lost = 0;
            m_fault = 0; m_s1 = 0; m_s2 = 0; m_mask = '0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_lock;
            if (relock_req) begin
                if (m_ph == PH_FAULT) begin m_fault = 0; m_retry = 0; end
                m_ph = PH_RST; m_el = 0;
            end else begin
                case (m_ph)
                    PH_RST: if (m_el == RST_CYC - 1) begin m_ph = PH_WAIT; m_el = 0; end
                            else m_el++;
                    PH_WAIT: begin
                        if (ls) begin m_ph = PH_FILT; m_el = 0; end
                        else if (m_el == TIMEOUT - 1) begin
                            if (m_retry < 15) m_retry++;
                            m_ph = PH_RST; m_el = 0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
                            if (m_retry == MAX_RETRY) begin m_ph = PH_FAULT; m_fault = 1; end
`endif
                        end else m_el++;
                    end
                    PH_FILT: begin
                        if (!ls) begin m_ph = PH_WAIT; m_el = 0; end
                        else if (m_el == LOCK_FILT - 1) begin m_mask = ch_mask; m_ph = PH_EN; m_el = 0; end
                        else m_el++;
                    end
                    PH_EN, PH_RUN: begin
                        if (!ls) begin
                            if (m_lost < 15) m_lost++;
                            m_ph = PH_RST; m_el = 0;
                        end else if (m_ph == PH_EN && m_el == NUM_CLK * STAGGER - 1) begin
                            m_ph = PH_RUN; m_el = 0;
                        end else m_el++;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [2:0] exp_enclk();
        logic [2:0] e;
        e = '0;
        for (int i = 0; i < NUM_CLK; i++)
            if (m_ph == PH_RUN || (m_ph == PH_EN && m_el >= i * STAGGER)) e[i] = m_mask[i];
        return e;
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pll_reset", 32'(pll_reset), 32'(m_ph == PH_RST || m_ph == PH_FAULT));
            check("enclk", 32'(enclk), 32'(exp_enclk()));
            check("sys_rst_n", 32'(sys_rst_n), 32'(m_ph == PH_RUN));
            check("ready", 32'(ready), 32'(m_ph == PH_RUN));
            check("fault", 32'(fault), 32'(m_fault));
            check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
            check("lost_cnt", 32'(lost_cnt), 32'(m_lost));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        cyc(2);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pll_lock = 1'b0; ch_mask = 3'b111; relock_req = 1'b0;
        cyc(3);
        cmp_en = 1'b1;
        cyc(1);
        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_enclk", 32'(enclk), 32'd0);

        // Bring-up: lock rises at cycle 30, all channels enabled
        #1 rst_n = 1'b1;
        cyc(15); check("pllrst_hold_15", 32'(pll_reset), 32'd1);
        cyc(1);  check("pllrst_fall_16", 32'(pll_reset), 32'd0);
        cyc(14); #1 pll_lock = 1'b1;
        cyc(66); check("enclk_c96", 32'(enclk), 32'b000);
        cyc(1);  check("enclk_c97", 32'(enclk), 32'b001);
        cyc(8);  check("enclk_c105", 32'(enclk), 32'b011);
        cyc(8);  check("enclk_c113", 32'(enclk), 32'b111);
        cyc(7);  check("ready_c120", 32'(ready), 32'd0);
        cyc(1);  check("ready_c121", 32'(ready), 32'd1);
                 check("sys_rst_n_c121", 32'(sys_rst_n), 32'd1);
                 check("retry_c121", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN: outputs drop 3 cycles later
        cyc(29); #1 pll_lock = 1'b0;
        cyc(2);  check("ready_before_loss", 32'(ready), 32'd1);
        cyc(1);  check("loss_ready", 32'(ready), 32'd0);
                 check("loss_enclk", 32'(enclk), 32'd0);
                 check("loss_pll_reset", 32'(pll_reset), 32'd1);
                 check("loss_lost_cnt", 32'(lost_cnt), 32'd1);

        // Masked channel and relock in RUN
        #1 pll_lock = 1'b1; ch_mask = 3'b101;
        cyc(300); check("mask101_enclk", 32'(enclk), 32'b101);
        #1 relock_req = 1'b1;
        cyc(1); #1 relock_req = 1'b0;
        check("relock_ready", 32'(ready), 32'd0);
        check("relock_lost", 32'(lost_cnt), 32'd1);

        // One-cycle lock glitch at filter cycle 40 restarts the filter
        @(negedge clk); #1 rst_n = 1'b0; pll_lock = 1'b1; ch_mask = 3'b111;
        cyc(2); #1 rst_n = 1'b1;
        cyc(57); #1 pll_lock = 1'b0;
        cyc(1);  #1 pll_lock = 1'b1;
        cyc(23); check("glitch_c81", 32'(enclk), 32'd0);
        cyc(43); check("glitch_c124", 32'(enclk), 32'd0);
        cyc(1);  check("glitch_c125", 32'(enclk), 32'b001);

        // Lock never arrives: periodic retries
        @(negedge clk); #1 rst_n = 1'b0; pll_lock = 1'b0;
        cyc(2); #1 rst_n = 1'b1;
        cyc(115); check("retry_c115", 32'(retry_cnt), 32'd0);
                  check("retry_c115_rst", 32'(pll_reset), 32'd0);
        cyc(1);   check("retry_c116", 32'(retry_cnt), 32'd1);
                  check("retry_c116_rst", 32'(pll_reset), 32'd1);
        cyc(116); check("retry_c232", 32'(retry_cnt), 32'd2);
        cyc(116); check("retry_c348", 32'(retry_cnt), 32'd3);
`ifdef PLLSEQ_RETRY_LIMIT_EN
        check("fault_set", 32'(fault), 32'd1);
        cyc(500); check("fault_hold_rst", 32'(pll_reset), 32'd1);
        #1 relock_req = 1'b1;
        cyc(1); #1 relock_req = 1'b0;
        check("fault_clear", 32'(fault), 32'd0);
        check("fault_retry_clear", 32'(retry_cnt), 32'd0);
`else
        check("fault_tied", 32'(fault), 32'd0);
        cyc(1500); check("retry_saturate", 32'(retry_cnt), 32'd15);
`endif

        // Randomized lock, mask, relock and reset traffic
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            @(negedge clk);
            #1;
            pll_lock = ($urandom_range(0, 3) != 0);
            len = pll_lock ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) begin
                pll_lock = 1'b0;
                len = int'($urandom_range(100, 400));
            end
            ch_mask = 3'($urandom);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                #1;
                relock_req = ($urandom_range(0, 199) == 0);
                rst_n = ($urandom_range(0, 999) != 0);
            end
            relock_req = 1'b0;
            rst_n = 1'b1;
        end

        cyc(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Parametrised PLL bring-up controller that sits beside the Gowin PLL wrapper and drives its reset and per-output clock enables. It pulses PLL reset, waits for lock with a timeout and retry, and filters lock until it is stable. It then enables the output clocks one at a time, releases a downstream system reset, and watches for loss of lock. On loss of lock or a software relock request it re-runs the whole sequence.

Parameters:
NUM_CLK, 3, number of PLL output channels with individual enables (1..7)
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_FILT, 64, consecutive synchronised-lock-high cycles required before lock is accepted (>=1)
TIMEOUT_CYCLES, 65535, cycles allowed in WAIT_LOCK before a retry (>=1)
STAGGER, 8, cycles between successive channel enables (>=1)
CNT_W, 16, width of the internal timer; must hold max(RST_CYCLES, LOCK_FILT, TIMEOUT_CYCLES, STAGGER)
MAX_RETRY, 7, retry limit; used only with the optional feature

Ports:
clkin  input  1  reference clock; also the PLL input clock
resetn  input  1  asynchronous active-low reset
pll_lock  input  1  PLL lock, asynchronous; passes through a 2-flop synchroniser (lock_s)
ch_mask  input  NUM_CLK  channels to enable; sampled on entry to ENABLE
relock_req  input  1  single-cycle request to restart the sequence
pll_reset  output  1  drives the PLL reset, active high
enclk  output  NUM_CLK  per-channel clock enables to the PLL
sys_rst_n  output  1  downstream synchronous reset, active low
ready  output  1  high while in RUN
fault  output  1  sticky retry-limit fault (optional feature only, else tied 0)
retry_cnt  output  4  saturating count of lock timeouts since reset
lost_cnt  output  4  saturating count of lock losses seen in RUN

Behaviour:
- Clock and reset: one clock, clkin. Reset is asynchronous and active-low on resetn.
- Output registering: every output is a register. A decision made in cycle n is visible at the outputs in cycle n+1.
- Values while resetn is low: state=PLLRST, timer=0, pll_reset=1, enclk=0, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lost_cnt=0, synchroniser=0.
- PLLRST:
  - pll_reset=1 and enclk=0.
  - After RST_CYCLES cycles: pll_reset=0, timer=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1: go to FILTER with timer=0.
  - timer reaches TIMEOUT_CYCLES-1 with lock_s=0: retry_cnt+1 (saturates at 15), go to PLLRST.
- FILTER:
  - lock_s=0 on any cycle: go to WAIT_LOCK with timer=0.
  - LOCK_FILT consecutive high cycles: latch ch_mask, idx=0, go to ENABLE.
- ENABLE:
  - On entry, and every STAGGER cycles after it, set enclk[idx]=mask[idx] and increment idx.
  - After idx=NUM_CLK-1 has been applied and STAGGER further cycles have passed, go to RUN.
  - sys_rst_n=1 and ready=1 on the first RUN cycle.
  - Masked channels stay 0 but still take their stagger slot.
- RUN: lock_s=0 sets lost_cnt+1 (saturates at 15), clears enclk, sys_rst_n and ready, and goes to PLLRST.
- Lock loss during ENABLE: handled the same way as in RUN, including the lost_cnt increment.
- relock_req, any state:
  - Clears enclk, sys_rst_n and ready and goes to PLLRST with timer=0.
  - Does not change lost_cnt or retry_cnt.
  - relock_req has priority over a lock loss in the same cycle.
- Counter saturation: retry_cnt and lost_cnt saturate and never wrap.
- Mid-sequence reset: asserting resetn low at any point returns every output to its reset value immediately (asynchronous).

Optional Feature:
Macro PLLSEQ_RETRY_LIMIT_EN.
- Defined:
  - The timeout that brings retry_cnt to MAX_RETRY sets fault=1 and moves to state FAULT instead of PLLRST.
  - FAULT holds pll_reset=1, enclk=0, sys_rst_n=0 and ready=0.
  - FAULT is left only by relock_req, which clears fault and retry_cnt and goes to PLLRST, or by resetn.
- Not defined: retries continue indefinitely, fault is constant 0, and the FAULT state does not exist.

Test Plan:
1. NUM_CLK=3, RST_CYCLES=16, LOCK_FILT=64, STAGGER=8, mask=3'b111; pll_lock rises at cycle 30 -> pll_reset falls at cycle 16; enclk[0], enclk[1], enclk[2] rise 8 cycles apart; sys_rst_n=1 and ready=1 8 cycles after enclk[2]; retry_cnt=0.
2. pll_lock held 0 with TIMEOUT_CYCLES=100 -> pll_reset is re-pulsed every 116 cycles (16 reset + 100 wait); retry_cnt counts 1, 2, 3 and saturates at 15.
3. pll_lock glitches low for 1 cycle at filter cycle 40 -> FILTER restarts; enclk first rises 64 clean lock cycles after the glitch.
4. In RUN, pll_lock drops -> 3 cycles later enclk=0, sys_rst_n=0, ready=0, pll_reset=1, lost_cnt=1; a full re-sequence follows once lock returns.
5. mask=3'b101 with relock_req pulsed in RUN -> enclk[1] stays 0 throughout; the sequence restarts; lost_cnt does not change.
6. PLLSEQ_RETRY_LIMIT_EN with MAX_RETRY=3 and lock held 0 -> fault=1 after the 3rd timeout and pll_reset stays 1; relock_req clears fault, sets retry_cnt=0 and restarts the sequence.
